// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults, window lane layout, FSM encoding and window shift helper.
package sobel_pkg;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int TOP = 48;
  localparam int MID = 24;
  localparam int BOT = 0;
  typedef enum logic [1:0] {S_FILL = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  // Drops the left column of each row and appends the new right column.
  function automatic logic [71:0] win_shift(logic [71:0] w, logic [7:0] t, logic [7:0] m, logic [7:0] b);
    return {w[TOP+15 -: 16], t, w[MID+15 -: 16], m, w[BOT+15 -: 16], b};
  endfunction
endpackage

// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel-in and window-out handshakes plus frame status.
interface sobel_window_gen_if;
  logic [7:0] pix_in;
  logic pix_valid;
  logic pix_ready;
  logic [71:0] win_out;
  logic win_valid;
  logic win_ready;
  logic [18:0] win_count;
  logic frame_done;
  modport slave(input pix_in, pix_valid, win_ready, output pix_ready, win_out, win_valid, win_count, frame_done);
  modport master(output pix_in, pix_valid, win_ready, input pix_ready, win_out, win_valid, win_count, frame_done);
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one row of pixels, read-before-write at a single address.
module sobel_line_buffer #(parameter int DEPTH = 640) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] mem [DEPTH];
  assign dout = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster pixels to 3x3 windows for a Sobel core.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input logic clk,
  input logic reset,
  sobel_window_gen_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [18:0] LAST = 19'((IMG_W - 2) * (IMG_H - 2) - 1);
  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0] l1_q, l2_q;
  logic [71:0] sh, sh_n;
  logic acc, consume, load;
  assign acc = s.pix_valid && s.pix_ready;
  assign consume = s.win_valid && s.win_ready;
  assign load = acc && row >= RW'(2) && col >= CW'(2);
  assign sh_n = win_shift(sh, l2_q, l1_q, s.pix_in);
  sobel_line_buffer #(.DEPTH(IMG_W)) u_l1 (.clk, .we(acc), .addr(col), .din(s.pix_in), .dout(l1_q));
  sobel_line_buffer #(.DEPTH(IMG_W)) u_l2 (.clk, .we(acc), .addr(col), .din(l1_q), .dout(l2_q));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_FILL;
    else state <= state_n;
  always_comb begin
    state_n = state == S_DONE ? S_FILL :
              (state == S_FILL && acc && row == RW'(1) && col == COL_MAX) ? S_RUN :
              (state == S_RUN && consume && s.win_count == LAST) ? S_DONE : state;
    s.pix_ready = state != S_DONE && (!s.win_valid || s.win_ready);
    s.frame_done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      col <= '0;
      row <= '0;
      sh <= '0;
      s.win_out <= '0;
      s.win_valid <= 1'b0;
      s.win_count <= '0;
    end else begin
      if (acc) begin
        col <= col == COL_MAX ? '0 : col + 1'b1;
        if (col == COL_MAX) row <= row == ROW_MAX ? '0 : row + 1'b1;
        sh <= sh_n;
      end
      if (load) s.win_out <= sh_n;
      s.win_valid <= load || (s.win_valid && !s.win_ready);
      s.win_count <= s.frame_done ? '0 : s.win_count + 19'(consume);
    end
endmodule
